fetch_ctrl: RTL and testbench

Sequencer for the instruction-fetch stage (PCmux, PC, PCAdder, IMEM, IFID). It drives PC count-enable, PCmux select and redirect target, and IF/ID write-enable and flush. It owns the post-reset boot delay, hazard stalls, branch redirects and halt. It replaces the hand-driven CNTEN/PCsel stimulus and sits beside the IF stage, taking requests from the ID/EX hazard and branch logic.

---
 rtl/fetch_ctrl_pkg.sv | 19 +
 rtl/fetch_perf_cnt.sv | 29 ++
 rtl/fetch_ctrl.sv | 150 +++++++++++++++
 tb/tb_fetch_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_ctrl_pkg.sv
// rtl/fetch_ctrl_pkg.sv - shared state encoding and widths for the fetch sequencer
package fetch_ctrl_pkg;

    localparam int BOOT_CNT_W  = 4;
    localparam int FLUSH_CNT_W = 2;

    localparam logic PCSEL_SEQ = 1'b0;
    localparam logic PCSEL_TGT = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_BOOT   = 3'd1,
        ST_RUN    = 3'd2,
        ST_STALL  = 3'd3,
        ST_REDIR  = 3'd4,
        ST_HALTED = 3'd5
    } state_e;

endpackage

// File: rtl/fetch_perf_cnt.sv
// rtl/fetch_perf_cnt.sv - 16-bit saturating event counter with synchronous clear
module fetch_perf_cnt (
    input  logic        clk,
    input  logic        clr,
    input  logic        inc,
    output logic [15:0] count
);

    logic [15:0] count_q;
    logic [15:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != 16'hFFFF)) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - IF-stage sequencer (boot, stall, redirect, halt); FETCH_CTRL_PERF_EN adds STALL_CNT/REDIR_CNT
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int BOOT_CYCLES = 2,
    parameter int FLUSH_SLOTS = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic              HALT_REQ,
    input  logic              STALL,
    input  logic              BR_TAKEN,
    input  logic [ADDR_W-1:0] BR_TARGET,
    output logic              CNTEN,
    output logic              PCsel,
    output logic [ADDR_W-1:0] PC_TGT,
    output logic              IFID_WE,
    output logic              IFID_FLUSH,
    output logic              BUSY,
    output logic [2:0]        STATE
`ifdef FETCH_CTRL_PERF_EN
    ,
    output logic [15:0]       STALL_CNT,
    output logic [15:0]       REDIR_CNT
`endif
);

    localparam logic [BOOT_CNT_W-1:0] BOOT_LOAD  = BOOT_CNT_W'(BOOT_CYCLES - 1);
    localparam logic [BOOT_CNT_W-1:0] FLUSH_LOAD = BOOT_CNT_W'(FLUSH_CNT_W'(FLUSH_SLOTS - 1));

    state_e                  state_q,  state_d;
    logic [BOOT_CNT_W-1:0]   cnt_q,    cnt_d;
    logic [ADDR_W-1:0]       pc_tgt_q, pc_tgt_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pc_tgt_d = pc_tgt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (START) begin
                    state_d = ST_BOOT;
                    cnt_d   = BOOT_LOAD;
                end
            end
            ST_BOOT: begin
                if (HALT_REQ) begin
                    state_d = ST_HALTED;
                end else if (cnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RUN, ST_STALL: begin
                // a stall coinciding with a branch is dropped: its slot gets flushed anyway
                if (HALT_REQ) begin
                    state_d = ST_HALTED;
                end else if (BR_TAKEN) begin
                    state_d  = ST_REDIR;
                    pc_tgt_d = BR_TARGET;
                    cnt_d    = FLUSH_LOAD;
                end else if (STALL) begin
                    state_d = ST_STALL;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_REDIR: begin
                if (HALT_REQ) begin
                    state_d = ST_HALTED;
                end else if (BR_TAKEN) begin
                    pc_tgt_d = BR_TARGET;
                    cnt_d    = FLUSH_LOAD;
                end else if (cnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_HALTED: begin
                if (START) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            pc_tgt_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pc_tgt_q <= pc_tgt_d;
        end
    end

    // the counter sits at FLUSH_LOAD only in the first cycle of a (re)started redirect
    always_comb begin
        CNTEN      = 1'b0;
        PCsel      = PCSEL_SEQ;
        IFID_WE    = 1'b0;
        IFID_FLUSH = 1'b0;
        unique case (state_q)
            ST_BOOT: IFID_FLUSH = 1'b1;
            ST_RUN: begin
                CNTEN   = 1'b1;
                IFID_WE = 1'b1;
            end
            ST_REDIR: begin
                CNTEN      = 1'b1;
                IFID_WE    = 1'b1;
                IFID_FLUSH = 1'b1;
                PCsel      = (cnt_q == FLUSH_LOAD) ? PCSEL_TGT : PCSEL_SEQ;
            end
            default: ;
        endcase
    end

    assign BUSY   = (state_q != ST_IDLE) && (state_q != ST_HALTED);
    assign STATE  = state_q;
    assign PC_TGT = pc_tgt_q;

`ifdef FETCH_CTRL_PERF_EN
    logic redir_entry;

    assign redir_entry = (state_d == ST_REDIR) && ((state_q != ST_REDIR) || BR_TAKEN);

    fetch_perf_cnt u_stall_cnt (
        .clk   (CLK),
        .clr   (RST),
        .inc   (state_q == ST_STALL),
        .count (STALL_CNT)
    );

    fetch_perf_cnt u_redir_cnt (
        .clk   (CLK),
        .clr   (RST),
        .inc   (redir_entry),
        .count (REDIR_CNT)
    );
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - scoreboard bench for fetch_ctrl with a PC/PCmux model; FETCH_CTRL_PERF_EN checks counters
module tb_fetch_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        START = 1'b0;
    logic        HALT_REQ = 1'b0;
    logic        STALL = 1'b0;
    logic        BR_TAKEN = 1'b0;
    logic [31:0] BR_TARGET = '0;
    logic        CNTEN, PCsel, IFID_WE, IFID_FLUSH, BUSY;
    logic [31:0] PC_TGT;
    logic [2:0]  STATE;
`ifdef FETCH_CTRL_PERF_EN
    logic [15:0] STALL_CNT, REDIR_CNT;
`endif

    fetch_ctrl #(.ADDR_W(32), .BOOT_CYCLES(2), .FLUSH_SLOTS(1)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .START      (START),
        .HALT_REQ   (HALT_REQ),
        .STALL      (STALL),
        .BR_TAKEN   (BR_TAKEN),
        .BR_TARGET  (BR_TARGET),
        .CNTEN      (CNTEN),
        .PCsel      (PCsel),
        .PC_TGT     (PC_TGT),
        .IFID_WE    (IFID_WE),
        .IFID_FLUSH (IFID_FLUSH),
        .BUSY       (BUSY),
        .STATE      (STATE)
`ifdef FETCH_CTRL_PERF_EN
        ,
        .STALL_CNT  (STALL_CNT),
        .REDIR_CNT  (REDIR_CNT)
`endif
    );

    always #5 CLK = ~CLK;

    // PC register + PCmux + PC adder of the IF stage
    logic [31:0] pc_m;
    always @(posedge CLK) begin
        if (RST) pc_m <= '0;
        else if (CNTEN) pc_m <= PCsel ? PC_TGT : pc_m + 32'd4;
    end

    typedef struct packed {
        logic        rst, start, halt, stall, br;
        logic [31:0] tgt;
        logic [2:0]  st;
        logic        pcs;
        logic [31:0] etgt;
    } row_t;

    logic [39:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;
    logic [39:0] got, want;

    function automatic row_t mk(logic rst, logic start, logic halt, logic stall, logic br,
                                logic [31:0] tgt, logic [2:0] st, logic pcs, logic [31:0] etgt);
        row_t r;
        r = '{rst, start, halt, stall, br, tgt, st, pcs, etgt};
        return r;
    endfunction

    // outputs expected in each state: {STATE, CNTEN, PCsel, IFID_WE, IFID_FLUSH, BUSY, PC_TGT}
    function automatic logic [39:0] exp_vec(logic [2:0] st, logic pcs, logic [31:0] tgt);
        logic cn, we, fl, bz;
        cn = 1'b0; we = 1'b0; fl = 1'b0; bz = 1'b0;
        case (st)
            3'd1: begin fl = 1'b1; bz = 1'b1; end
            3'd2: begin cn = 1'b1; we = 1'b1; bz = 1'b1; end
            3'd3: bz = 1'b1;
            3'd4: begin cn = 1'b1; we = 1'b1; fl = 1'b1; bz = 1'b1; end
            default: ;
        endcase
        return {st, cn, pcs, we, fl, bz, tgt};
    endfunction

    function automatic logic [39:0] obs();
        return {STATE, CNTEN, PCsel, IFID_WE, IFID_FLUSH, BUSY, PC_TGT};
    endfunction

    task automatic apply(input row_t r);
        RST = r.rst; START = r.start; HALT_REQ = r.halt;
        STALL = r.stall; BR_TAKEN = r.br; BR_TARGET = r.tgt;
        exp_q.push_back(exp_vec(r.st, r.pcs, r.etgt));
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        row_t rows[2];
        rows[0] = mk(1, 0, 0, 0, 0, 32'h0,   3'd0, 0, 32'h0);
        rows[1] = mk(1, 1, 0, 1, 1, 32'h123, 3'd0, 0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            apply(rows[i]);
            got = obs(); want = exp_q.pop_front(); n_cmp++;
            if (got !== want) begin n_err++; $display("FAIL reset[%0d] got=%h want=%h", i, got, want); end
        end
    endtask

    task automatic test_boot();
        row_t rows[5];
        rows[0] = mk(0, 1, 0, 0, 0, 32'h0,   3'd1, 0, 32'h0);
        rows[1] = mk(0, 0, 0, 1, 1, 32'h999, 3'd1, 0, 32'h0);
        rows[2] = mk(0, 1, 0, 0, 0, 32'h0,   3'd2, 0, 32'h0);
        rows[3] = mk(0, 0, 0, 0, 0, 32'h0,   3'd2, 0, 32'h0);
        rows[4] = mk(0, 0, 0, 0, 0, 32'h0,   3'd2, 0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            apply(rows[i]);
            got = obs(); want = exp_q.pop_front(); n_cmp++;
            if (got !== want) begin n_err++; $display("FAIL boot[%0d] got=%h want=%h", i, got, want); end
            if (i >= 2) begin
                n_cmp++;
                if (pc_m !== 32'(4 * (i - 2))) begin
                    n_err++; $display("FAIL boot_pc[%0d] got=%h want=%h", i, pc_m, 32'(4 * (i - 2)));
                end
            end
        end
    endtask

    task automatic test_stall();
        row_t rows[5];
        logic [31:0] pc_want[5];
        pc_want = '{32'hC, 32'hC, 32'hC, 32'hC, 32'h10};
        rows[0] = mk(0, 0, 0, 1, 0, 32'h0, 3'd3, 0, 32'h0);
        rows[1] = mk(0, 0, 0, 1, 0, 32'h0, 3'd3, 0, 32'h0);
        rows[2] = mk(0, 0, 0, 1, 0, 32'h0, 3'd3, 0, 32'h0);
        rows[3] = mk(0, 0, 0, 0, 0, 32'h0, 3'd2, 0, 32'h0);
        rows[4] = mk(0, 0, 0, 0, 0, 32'h0, 3'd2, 0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            apply(rows[i]);
            got = obs(); want = exp_q.pop_front(); n_cmp++;
            if (got !== want) begin n_err++; $display("FAIL stall[%0d] got=%h want=%h", i, got, want); end
            n_cmp++;
            if (pc_m !== pc_want[i]) begin n_err++; $display("FAIL stall_pc[%0d] got=%h want=%h", i, pc_m, pc_want[i]); end
        end
`ifdef FETCH_CTRL_PERF_EN
        n_cmp++;
        if (STALL_CNT !== 16'd3) begin n_err++; $display("FAIL stall_cnt got=%0d want=3", STALL_CNT); end
`endif
    endtask

    task automatic test_branch();
        row_t rows[3];
        logic [31:0] pc_want[3];
        pc_want = '{32'h14, 32'h40, 32'h44};
        rows[0] = mk(0, 0, 0, 0, 1, 32'h40, 3'd4, 1, 32'h40);
        rows[1] = mk(0, 0, 0, 1, 0, 32'h0,  3'd2, 0, 32'h40);
        rows[2] = mk(0, 0, 0, 0, 0, 32'h0,  3'd2, 0, 32'h40);
        for (int i = 0; i < 3; i++) begin
            apply(rows[i]);
            got = obs(); want = exp_q.pop_front(); n_cmp++;
            if (got !== want) begin n_err++; $display("FAIL branch[%0d] got=%h want=%h", i, got, want); end
            n_cmp++;
            if (pc_m !== pc_want[i]) begin n_err++; $display("FAIL branch_pc[%0d] got=%h want=%h", i, pc_m, pc_want[i]); end
        end
    endtask

    task automatic test_back_to_back();
        row_t rows[4];
        logic [31:0] pc_want[4];
        pc_want = '{32'h48, 32'h80, 32'hC0, 32'hC4};
        rows[0] = mk(0, 0, 0, 1, 1, 32'h80, 3'd4, 1, 32'h80);
        rows[1] = mk(0, 0, 0, 0, 1, 32'hC0, 3'd4, 1, 32'hC0);
        rows[2] = mk(0, 0, 0, 0, 0, 32'h0,  3'd2, 0, 32'hC0);
        rows[3] = mk(0, 0, 0, 0, 0, 32'h0,  3'd2, 0, 32'hC0);
        for (int i = 0; i < 4; i++) begin
            apply(rows[i]);
            got = obs(); want = exp_q.pop_front(); n_cmp++;
            if (got !== want) begin n_err++; $display("FAIL b2b[%0d] got=%h want=%h", i, got, want); end
            n_cmp++;
            if (pc_m !== pc_want[i]) begin n_err++; $display("FAIL b2b_pc[%0d] got=%h want=%h", i, pc_m, pc_want[i]); end
        end
`ifdef FETCH_CTRL_PERF_EN
        n_cmp++;
        if (REDIR_CNT !== 16'd3) begin n_err++; $display("FAIL redir_cnt got=%0d want=3", REDIR_CNT); end
        n_cmp++;
        if (STALL_CNT !== 16'd3) begin n_err++; $display("FAIL stall_cnt_b2b got=%0d want=3", STALL_CNT); end
`endif
    endtask

    task automatic test_halt();
        row_t rows[4];
        logic [31:0] pc_want[4];
        pc_want = '{32'hC8, 32'hC8, 32'hC8, 32'hCC};
        rows[0] = mk(0, 0, 1, 0, 1, 32'h200, 3'd5, 0, 32'hC0);
        rows[1] = mk(0, 0, 0, 1, 1, 32'h300, 3'd5, 0, 32'hC0);
        rows[2] = mk(0, 1, 0, 0, 0, 32'h0,   3'd2, 0, 32'hC0);
        rows[3] = mk(0, 0, 0, 0, 0, 32'h0,   3'd2, 0, 32'hC0);
        for (int i = 0; i < 4; i++) begin
            apply(rows[i]);
            got = obs(); want = exp_q.pop_front(); n_cmp++;
            if (got !== want) begin n_err++; $display("FAIL halt[%0d] got=%h want=%h", i, got, want); end
            n_cmp++;
            if (pc_m !== pc_want[i]) begin n_err++; $display("FAIL halt_pc[%0d] got=%h want=%h", i, pc_m, pc_want[i]); end
        end
    endtask

    task automatic test_reset_mid();
        row_t rows[5];
        rows[0] = mk(0, 0, 0, 0, 1, 32'h100, 3'd4, 1, 32'h100);
        rows[1] = mk(1, 0, 0, 1, 1, 32'h300, 3'd0, 0, 32'h0);
        rows[2] = mk(0, 1, 0, 0, 0, 32'h0,   3'd1, 0, 32'h0);
        rows[3] = mk(1, 0, 1, 0, 0, 32'h0,   3'd0, 0, 32'h0);
        rows[4] = mk(0, 0, 0, 0, 0, 32'h0,   3'd0, 0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            apply(rows[i]);
            got = obs(); want = exp_q.pop_front(); n_cmp++;
            if (got !== want) begin n_err++; $display("FAIL reset_mid[%0d] got=%h want=%h", i, got, want); end
`ifdef FETCH_CTRL_PERF_EN
            if (i == 1) begin
                n_cmp++;
                if ({STALL_CNT, REDIR_CNT} !== 32'h0) begin
                    n_err++; $display("FAIL perf_clear got=%h want=0", {STALL_CNT, REDIR_CNT});
                end
            end
`endif
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        @(negedge CLK);
        test_reset();
        test_boot();
        test_stall();
        test_branch();
        test_back_to_back();
        test_halt();
        test_reset_mid();
        n_cmp++;
        if (exp_q.size() != 0) begin n_err++; $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
